ch_data_aggregator: RTL

- Downstream consumer of the cluster-head role check stage. That stage raises forAggregation/done once the node knows it is a cluster head.
- When enabled as cluster head, this block reads the member-reading count and up to MAX_MEMBERS 16-bit member readings from node memory.
- It computes their floor average with a sequential restoring divider.
- It writes the average and the used count back to memory for the transmit stage, then asserts done.

---
 rtl/ch_data_aggregator_if.sv | 25 ++
 rtl/ch_data_aggregator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ch_data_aggregator_if.sv
// Node-memory bus between the aggregator and the shared memory.
// Synchronous read: data_in follows address by one cycle.
interface ch_data_aggregator_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic [WORD_WIDTH-1:0] data_in;

  modport master (
    output address,
    output wr_en,
    output data_out,
    input  data_in
  );

  modport slave (
    input  address,
    input  wr_en,
    input  data_out,
    output data_in
  );
endinterface

// File: rtl/ch_data_aggregator.sv
// Cluster-head aggregation: reads member readings, floor-averages them,
// writes average and used count back to node memory.
module ch_data_aggregator #(
  parameter int WORD_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 11,
  parameter int MAX_MEMBERS = 8,
  parameter int ADDR_STRIDE = 2,
  parameter logic [ADDR_WIDTH-1:0] COUNT_ADDR  = 11'h010,
  parameter logic [ADDR_WIDTH-1:0] MEMBER_BASE = 11'h012,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR    = 11'h030
) (
  input  logic clock,
  input  logic nrst,
  input  logic en,
  input  logic start,
  input  logic forAggregation,
  output logic done,
  ch_data_aggregator_if.master mem
);

  localparam int CW = $clog2(MAX_MEMBERS) + 1;
  localparam int SW = WORD_WIDTH + $clog2(MAX_MEMBERS);
  localparam int DW = $clog2(SW + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [CW-1:0] MAXM = CW'(MAX_MEMBERS);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_WAIT, S_RD_CNT, S_MEM_WAIT, S_RD_MEM,
    S_DIV, S_WR_AVG, S_GAP1, S_WR_CNT, S_GAP2, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         m_q, m_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;

  logic [CW-1:0] m_cap;
  logic [CW:0]   trial;
  logic          ge;
  logic [CW-1:0] rem_next;
  logic [SW-1:0] quo_next;

  assign mem.address  = addr_q;
  assign mem.wr_en    = wr_q;
  assign mem.data_out = dout_q;
  assign done         = done_q;

  // sum_q doubles as the dividend/quotient shift register during DIV
  always_comb begin
    m_cap = (mem.data_in > WORD_WIDTH'(MAX_MEMBERS)) ?
            MAXM : mem.data_in[CW-1:0];
    trial = {rem_q, sum_q[SW-1]};
    ge = (trial >= {1'b0, m_q});
    rem_next = ge ? CW'(trial - {1'b0, m_q}) : trial[CW-1:0];
    quo_next = {sum_q[SW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    wr_d    = 1'b0;
    done_d  = done_q;
    m_d     = m_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && start) begin
          if (!forAggregation) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = COUNT_ADDR;
            state_d = S_CNT_WAIT;
          end
        end
      end
      S_CNT_WAIT: state_d = S_RD_CNT;
      S_RD_CNT: begin
        m_d = m_cap;
        if (m_cap == '0) begin
          addr_d  = OUT_ADDR;
          dout_d  = '0;
          wr_d    = 1'b1;
          state_d = S_WR_AVG;
        end else begin
          addr_d  = MEMBER_BASE;
          idx_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (idx_q + CW'(1) < m_q) begin
          addr_d = addr_q + STRIDE;
          idx_d  = idx_q + CW'(1);
        end
        state_d = S_RD_MEM;
      end
      S_RD_MEM: begin
        sum_d = sum_q + SW'(mem.data_in);
        cnt_d = cnt_q + CW'(1);
        // stop issuing once the last reading's address is out
        if (idx_q + CW'(1) < m_q) begin
          addr_d = addr_q + STRIDE;
          idx_d  = idx_q + CW'(1);
        end
        if (cnt_q + CW'(1) == m_q) begin
          rem_d   = '0;
          dcnt_d  = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        sum_d  = quo_next;
        rem_d  = rem_next;
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DW'(SW - 1)) begin
          addr_d  = OUT_ADDR;
          dout_d  = quo_next[WORD_WIDTH-1:0];
          wr_d    = 1'b1;
          state_d = S_WR_AVG;
        end
      end
      S_WR_AVG: state_d = S_GAP1;
      S_GAP1: begin
        addr_d  = OUT_ADDR + STRIDE;
        dout_d  = WORD_WIDTH'(m_q);
        wr_d    = 1'b1;
        state_d = S_WR_CNT;
      end
      S_WR_CNT: state_d = S_GAP2;
      S_GAP2: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!en) begin
          done_d  = 1'b0;
          addr_d  = '0;
          dout_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      m_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      dcnt_q  <= dcnt_d;
    end
  end

endmodule
